// File: rtl/wb_pkg.sv
// Shared types and sizing helpers for the multi-port Wishbone RAM.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Enough for up to 15 wait states.
  localparam int WAIT_CNT_W = 4;

  function automatic int sel_w(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int port_w(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

endpackage

// File: rtl/wb_multiport_ram_if.sv
// Bundle of NUM_PORTS Wishbone classic slave ports, flattened per signal.
interface wb_multiport_ram_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);

  logic [NUM_PORTS-1:0]            CYC_I;
  logic [NUM_PORTS-1:0]            STB_I;
  logic [NUM_PORTS-1:0]            WE_I;
  logic [NUM_PORTS*ADDR_W-1:0]     ADR_I;
  logic [NUM_PORTS*DATA_W-1:0]     DAT_I;
  logic [NUM_PORTS*(DATA_W/8)-1:0] SEL_I;
  logic [NUM_PORTS*DATA_W-1:0]     DAT_O;
  logic [NUM_PORTS-1:0]            ACK_O;
  logic [NUM_PORTS-1:0]            ERR_O;

  modport master (
    output CYC_I, STB_I, WE_I, ADR_I, DAT_I, SEL_I,
    input  DAT_O, ACK_O, ERR_O
  );

  modport slave (
    input  CYC_I, STB_I, WE_I, ADR_I, DAT_I, SEL_I,
    output DAT_O, ACK_O, ERR_O
  );

endinterface

// File: rtl/wb_rr_arbiter.sv
// Combinational round-robin pick: first requesting port at or after ptr, wrapping.
module wb_rr_arbiter #(
  parameter  int NUM_PORTS = 2,
  localparam int PIDX_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PIDX_W-1:0]    ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic [PIDX_W-1:0]    idx,
  output logic                 any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    // Ports at or above the pointer take priority over the wrapped-around ones.
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!any && req[i] && (i >= int'(ptr))) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        idx      = PIDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!any && req[i] && (i < int'(ptr))) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        idx      = PIDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/wb_multiport_ram.sv
// Shared single-port word RAM behind NUM_PORTS Wishbone classic slaves with
// round-robin arbitration, wait states, byte writes and range errors.
module wb_multiport_ram
  import wb_pkg::*;
#(
  parameter int NUM_PORTS   = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input logic               CLK_I,
  input logic               RST_I,
  wb_multiport_ram_if.slave bus
);

  localparam int SEL_W   = sel_w(DATA_W);
  localparam int OFF_W   = $clog2(SEL_W);
  localparam int IDX_W   = idx_w(DEPTH);
  localparam int PIDX_W  = port_w(NUM_PORTS);
  localparam int WS_LAST = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DATA_W-1:0]     rd_data;

  state_t                state;
  logic [PIDX_W-1:0]     gnt;
  logic [NUM_PORTS-1:0]  gnt_oh;
  logic [PIDX_W-1:0]     ptr;
  logic [WAIT_CNT_W-1:0] cnt;
  logic                  oor_q;
  logic [IDX_W-1:0]      idx_q;

  logic [NUM_PORTS-1:0]  req;
  logic [NUM_PORTS-1:0]  arb_gnt;
  logic [PIDX_W-1:0]     arb_idx;
  logic                  arb_any;
  logic                  req_g;

  logic [PIDX_W-1:0]     sp;
  logic [ADDR_W-1:0]     sp_adr;
  logic [ADDR_W-1:0]     sp_word;
  logic [DATA_W-1:0]     sp_dat;
  logic [SEL_W-1:0]      sp_sel;
  logic                  sp_we;
  logic                  sp_oor;
  logic [IDX_W-1:0]      sp_idx;
  logic                  enter_resp;
  logic                  commit;

  assign req   = bus.CYC_I & bus.STB_I;
  assign req_g = |(req & gnt_oh);

  wb_rr_arbiter #(
    .NUM_PORTS(NUM_PORTS)
  ) u_arb (
    .req  (req),
    .ptr  (ptr),
    .grant(arb_gnt),
    .idx  (arb_idx),
    .any  (arb_any)
  );

  // With no wait states the grant edge is also the edge that enters RESP,
  // so the inputs come from the port the arbiter is picking right now.
  assign sp = (state == IDLE) ? arb_idx : gnt;

  always_comb begin
    sp_adr = '0;
    sp_dat = '0;
    sp_sel = '0;
    sp_we  = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (PIDX_W'(p) == sp) begin
        sp_adr = bus.ADR_I[p*ADDR_W +: ADDR_W];
        sp_dat = bus.DAT_I[p*DATA_W +: DATA_W];
        sp_sel = bus.SEL_I[p*SEL_W +: SEL_W];
        sp_we  = bus.WE_I[p];
      end
    end
  end

  assign sp_word = sp_adr >> OFF_W;
  assign sp_oor  = (sp_word >= ADDR_W'(DEPTH));
  assign sp_idx  = sp_word[IDX_W-1:0];

  // Reset low blocks the commit even when the FSM would otherwise leave IDLE.
  assign enter_resp = RST_I &&
                      (((state == IDLE) && arb_any && (WAIT_STATES == 0)) ||
                       ((state == WAIT) && req_g && (cnt == WAIT_CNT_W'(WS_LAST))));
  assign commit     = enter_resp && sp_we && !sp_oor;

  always_ff @(posedge CLK_I) begin
    if (commit) begin
      for (int b = 0; b < SEL_W; b++) begin
        if (sp_sel[b]) mem[sp_idx][b*8 +: 8] <= sp_dat[b*8 +: 8];
      end
    end
    if (state == RESP) rd_data <= mem[idx_q];
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_oh    <= '0;
      ptr       <= '0;
      cnt       <= '0;
      oor_q     <= 1'b0;
      idx_q     <= '0;
      bus.ACK_O <= '0;
      bus.ERR_O <= '0;
    end else begin
      bus.ACK_O <= '0;
      bus.ERR_O <= '0;
      if (enter_resp) begin
        oor_q <= sp_oor;
        idx_q <= sp_idx;
      end
      case (state)
        IDLE: begin
          if (arb_any) begin
            gnt    <= arb_idx;
            gnt_oh <= arb_gnt;
            cnt    <= '0;
            state  <= (WAIT_STATES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (!req_g)                             state <= IDLE;
          else if (cnt == WAIT_CNT_W'(WS_LAST))   state <= RESP;
          else                                    cnt   <= cnt + 1'b1;
        end
        RESP: begin
          bus.ACK_O <= oor_q ? '0 : gnt_oh;
          bus.ERR_O <= oor_q ? gnt_oh : '0;
          ptr       <= (gnt == PIDX_W'(NUM_PORTS - 1)) ? '0 : gnt + 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data is presented only on the port currently being acknowledged.
  always_comb begin
    bus.DAT_O = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (bus.ACK_O[p]) bus.DAT_O[p*DATA_W +: DATA_W] = rd_data;
    end
  end

endmodule

// File: tb/tb_wb_multiport_ram.sv
// Bench for wb_multiport_ram: one instance without and one with wait states.
module tb_wb_multiport_ram;

  logic clk;
  logic rst_n;

  logic [1:0]  cyc  [2];
  logic [1:0]  stb  [2];
  logic [1:0]  we   [2];
  logic [31:0] adr  [2][2];
  logic [31:0] dat  [2][2];
  logic [3:0]  sel  [2][2];
  logic [1:0]  ack  [2];
  logic [1:0]  err  [2];
  logic [31:0] dato [2][2];

  wb_multiport_ram_if #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32)) bus0 ();
  wb_multiport_ram_if #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32)) bus3 ();

  wb_multiport_ram #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .DEPTH(1024), .WAIT_STATES(0))
    dut0 (.CLK_I(clk), .RST_I(rst_n), .bus(bus0));
  wb_multiport_ram #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .DEPTH(1024), .WAIT_STATES(3))
    dut3 (.CLK_I(clk), .RST_I(rst_n), .bus(bus3));

  assign bus0.CYC_I = cyc[0];
  assign bus0.STB_I = stb[0];
  assign bus0.WE_I  = we[0];
  assign bus0.ADR_I = {adr[0][1], adr[0][0]};
  assign bus0.DAT_I = {dat[0][1], dat[0][0]};
  assign bus0.SEL_I = {sel[0][1], sel[0][0]};
  assign bus3.CYC_I = cyc[1];
  assign bus3.STB_I = stb[1];
  assign bus3.WE_I  = we[1];
  assign bus3.ADR_I = {adr[1][1], adr[1][0]};
  assign bus3.DAT_I = {dat[1][1], dat[1][0]};
  assign bus3.SEL_I = {sel[1][1], sel[1][0]};

  assign ack[0]     = bus0.ACK_O;
  assign err[0]     = bus0.ERR_O;
  assign ack[1]     = bus3.ACK_O;
  assign err[1]     = bus3.ERR_O;
  assign dato[0][0] = bus0.DAT_O[31:0];
  assign dato[0][1] = bus0.DAT_O[63:32];
  assign dato[1][0] = bus3.DAT_O[31:0];
  assign dato[1][1] = bus3.DAT_O[63:32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          port;
    bit          err;
    logic [31:0] data;
    bit          chk_data;
  } exp_t;

  typedef struct {
    int          port;
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    bit          exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  exp_t sbq0[$];
  exp_t sbq1[$];
  int   errors;
  int   checks;
  int   resp_cnt [2];
  logic [1:0] prev_resp [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic sb_push(input int d, input int p, input bit e, input logic [31:0] v, input bit c);
    exp_t x;
    x.port = p; x.err = e; x.data = v; x.chk_data = c;
    if (d == 0) sbq0.push_back(x);
    else        sbq1.push_back(x);
  endtask

  // Pops one expectation for every ACK/ERR pulse seen on either instance.
  task automatic monitor();
    for (int d = 0; d < 2; d++) begin
      logic [1:0] a;
      logic [1:0] e;
      int         p;
      exp_t       x;
      bit         have;
      a = ack[d];
      e = err[d];
      if ((a | e) != 2'b00) begin
        p = (a[1] | e[1]) ? 1 : 0;
        resp_cnt[d]++;
        chk("resp_onehot", $countones(a | e), 1);
        chk("ack_err_excl", {30'd0, a & e}, 0);
        chk("pulse_1cycle", {30'd0, prev_resp[d] & (a | e)}, 0);
        have = 1'b0;
        if (d == 0 && sbq0.size() > 0) begin x = sbq0.pop_front(); have = 1'b1; end
        if (d == 1 && sbq1.size() > 0) begin x = sbq1.pop_front(); have = 1'b1; end
        if (!have) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: dut %0d port %0d responded, none required", d, p);
        end else begin
          chk("resp_port", p, x.port);
          chk("resp_is_err", {31'd0, e[p]}, {31'd0, x.err});
          if (x.err)           chk("err_data", dato[d][p], 32'h0);
          else if (x.chk_data) chk("rd_data", dato[d][p], x.data);
          chk("other_port_data", dato[d][1-p], 32'h0);
        end
      end
      prev_resp[d] = a | e;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic drive(input int d, input int p, input bit w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] s);
    cyc[d][p] = 1'b1;
    stb[d][p] = 1'b1;
    we[d][p]  = w;
    adr[d][p] = a;
    dat[d][p] = wd;
    sel[d][p] = s;
  endtask

  task automatic release_port(input int d, input int p);
    cyc[d][p] = 1'b0;
    stb[d][p] = 1'b0;
  endtask

  // One complete transfer; latency counted in edges after the sampling edge.
  task automatic xfer(input int d, input int p, input bit w, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] s, input bit exp_err,
                      input logic [31:0] exp_rd, input int exp_lat);
    int n;
    bit got;
    sb_push(d, p, exp_err, exp_rd, !w);
    drive(d, p, w, a, wd, s);
    n   = 0;
    got = 1'b0;
    while (!got && n < 64) begin
      tick();
      n++;
      if (ack[d][p] || err[d][p]) got = 1'b1;
    end
    release_port(d, p);
    chk("latency", n - 1, exp_lat);
    tick();
    chk("resp_dropped", {30'd0, ack[d][p], err[d][p]}, 0);
  endtask

  vec_t tbl[14];
  int   base;

  initial begin
    errors = 0;
    checks = 0;
    for (int d = 0; d < 2; d++) begin
      cyc[d] = '0; stb[d] = '0; we[d] = '0;
      resp_cnt[d] = 0; prev_resp[d] = '0;
      for (int p = 0; p < 2; p++) begin
        adr[d][p] = '0; dat[d][p] = '0; sel[d][p] = '0;
      end
    end

    tbl[0]  = '{0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0};
    tbl[1]  = '{0, 1'b0, 32'h0000_0010, 32'h0,         4'hF, 1'b0, 32'hDEAD_BEEF};
    tbl[2]  = '{1, 1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 1'b0, 32'h0};
    tbl[3]  = '{1, 1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 1'b0, 32'h0};
    tbl[4]  = '{0, 1'b0, 32'h0000_0020, 32'h0,         4'hF, 1'b0, 32'h11BB_33DD};
    tbl[5]  = '{1, 1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0};
    tbl[6]  = '{1, 1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF, 1'b1, 32'h0};
    tbl[7]  = '{0, 1'b0, 32'h0000_0000, 32'h0,         4'hF, 1'b0, 32'hCAFE_F00D};
    tbl[8]  = '{0, 1'b0, 32'h0000_1003, 32'h0,         4'hF, 1'b1, 32'h0};
    tbl[9]  = '{1, 1'b1, 32'h0000_0024, 32'h5566_7788, 4'hF, 1'b0, 32'h0};
    tbl[10] = '{1, 1'b1, 32'h0000_0024, 32'hFFFF_FFFF, 4'h0, 1'b0, 32'h0};
    tbl[11] = '{0, 1'b0, 32'h0000_0024, 32'h0,         4'hF, 1'b0, 32'h5566_7788};
    tbl[12] = '{0, 1'b1, 32'h0000_0FFC, 32'h0BAD_C0DE, 4'hF, 1'b0, 32'h0};
    tbl[13] = '{1, 1'b0, 32'h0000_0FFF, 32'h0,         4'hF, 1'b0, 32'h0BAD_C0DE};

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      chk("reset_ack", {30'd0, ack[d]}, 0);
      chk("reset_err", {30'd0, err[d]}, 0);
      chk("reset_dat0", dato[d][0], 0);
      chk("reset_dat1", dato[d][1], 0);
    end
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 14; i++)
      xfer(0, tbl[i].port, tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel,
           tbl[i].exp_err, tbl[i].exp_rd, 1);

    // Both ports hammering from reset must alternate 0,1,0,1,...
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 8; k++)
      sb_push(0, k % 2, 1'b0, (k % 2 == 0) ? 32'hDEAD_BEEF : 32'h11BB_33DD, 1'b1);
    base = resp_cnt[0];
    drive(0, 0, 1'b0, 32'h10, 32'h0, 4'hF);
    drive(0, 1, 1'b0, 32'h20, 32'h0, 4'hF);
    for (int n = 0; n < 100 && resp_cnt[0] < base + 8; n++) tick();
    release_port(0, 0);
    release_port(0, 1);
    chk("rr_resp_count", resp_cnt[0] - base, 8);
    tick();

    // Wait-state instance: four-edge latency, then an aborted write.
    xfer(1, 0, 1'b1, 32'h4, 32'h0102_0304, 4'hF, 1'b0, 32'h0, 4);
    xfer(1, 0, 1'b0, 32'h4, 32'h0,         4'hF, 1'b0, 32'h0102_0304, 4);
    base = resp_cnt[1];
    drive(1, 0, 1'b1, 32'h4, 32'hFFFF_FFFF, 4'hF);
    tick();
    tick();
    tick();
    release_port(1, 0);
    for (int n = 0; n < 8; n++) tick();
    chk("abort_no_resp", resp_cnt[1] - base, 0);
    xfer(1, 0, 1'b0, 32'h4, 32'h0, 4'hF, 1'b0, 32'h0102_0304, 4);

    // Reset in the middle of a write's wait phase.
    drive(1, 0, 1'b1, 32'h4, 32'hFFFF_0000, 4'hF);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wait_ack", {30'd0, ack[1]}, 0);
    chk("rst_wait_err", {30'd0, err[1]}, 0);
    chk("rst_wait_dat", dato[1][0], 0);
    release_port(1, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    // Pointer is back at 0, so port 0 wins even though it was served last.
    sb_push(1, 0, 1'b0, 32'h0102_0304, 1'b1);
    sb_push(1, 1, 1'b0, 32'h0102_0304, 1'b1);
    base = resp_cnt[1];
    drive(1, 0, 1'b0, 32'h4, 32'h0, 4'hF);
    drive(1, 1, 1'b0, 32'h4, 32'h0, 4'hF);
    for (int n = 0; n < 100 && resp_cnt[1] < base + 2; n++) tick();
    release_port(1, 0);
    release_port(1, 1);
    chk("post_rst_resp_count", resp_cnt[1] - base, 2);
    tick();

    // Reset while an ACK is on the bus drops it at once.
    sb_push(0, 0, 1'b0, 32'hDEAD_BEEF, 1'b1);
    base = resp_cnt[0];
    drive(0, 0, 1'b0, 32'h10, 32'h0, 4'hF);
    for (int n = 0; n < 20 && resp_cnt[0] == base; n++) tick();
    chk("ack_seen_before_rst", resp_cnt[0] - base, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ack_drop", {30'd0, ack[0]}, 0);
    chk("rst_dat_drop", dato[0][0], 0);
    release_port(0, 0);
    tick();
    rst_n = 1'b1;
    tick();

    chk("sb_empty0", sbq0.size(), 0);
    chk("sb_empty1", sbq1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
